// File: rtl/blk_mem_pipe.sv
// Simple dual-port block memory with byte-lane writes, 1- or 2-stage read pipeline,
// write-first collision forwarding and a post-reset clear sequencer.
module blk_mem_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                ready,
  input  logic                                wea,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    bea,
  input  logic [ADDRESS_WIDTH-1:0]            addra,
  input  logic [DATA_WIDTH-1:0]               dina,
  input  logic                                reb,
  input  logic [ADDRESS_WIDTH-1:0]            addrb,
  output logic [DATA_WIDTH-1:0]               doutb,
  output logic                                doutb_valid
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("blk_mem_pipe: READ_LATENCY must be 1 or 2");
  end
  if (LANES * BYTE_WIDTH != DATA_WIDTH) begin : g_bad_lanes
    $error("blk_mem_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                     state;
  logic [ADDRESS_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]      mem [DEPTH];

  logic                       clr_we;
  logic                       wr_acc;
  logic                       rd_acc;
  logic                       hit;
  logic [DATA_WIDTH-1:0]      rd_word;
  logic [DATA_WIDTH-1:0]      dat_p1;
  logic                       vld_p1;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [LANES-1:0]      lane_en
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  // User traffic is only honoured once the clear has finished and outside reset.
  assign clr_we = (state == CLEAR) && !rst;
  assign wr_acc = ready && wea && !rst;
  assign rd_acc = ready && reb && !rst;
  assign hit    = wr_acc && (addra == addrb);
  assign rd_word = hit ? merge_lanes(mem[addrb], dina, bea) : mem[addrb];

  // Control: clear sequencer and ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      ready <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + ADDRESS_WIDTH'(1);
          if (&cnt) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  // Array write port
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (bea[i]) mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Stage 1: array read with write-first forwarding
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) dat_p1 <= rd_word;
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign doutb       = dat_p1;
    assign doutb_valid = vld_p1;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] dat_p2;
    logic                  vld_p2;

    // Stage 2: output register, holds when no read completes
    always_ff @(posedge clk) begin
      if (rst) begin
        dat_p2 <= '0;
        vld_p2 <= 1'b0;
      end else begin
        vld_p2 <= vld_p1;
        if (vld_p1) dat_p2 <= dat_p1;
      end
    end

    assign doutb       = dat_p2;
    assign doutb_valid = vld_p2;
  end

endmodule

// File: tb/tb_blk_mem_pipe.sv
// Randomised and directed bench for blk_mem_pipe against a cycle-level memory model.
module tb_blk_mem_pipe;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int RL    = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, ready, wea, reb, doutb_valid;
  logic [3:0]    bea, addra, addrb;
  logic [DW-1:0] dina, doutb;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_ready = 1'b0;
  int            m_clr = 0;
  int            cyc = 0;
  int            due_q [$];
  logic [DW-1:0] val_q [$];
  logic [DW-1:0] exp_dout = '0;
  bit            exp_valid = 1'b0;

  blk_mem_pipe #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BYTE_WIDTH(8),
    .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .wea(wea), .bea(bea), .addra(addra),
    .dina(dina), .reb(reb), .addrb(addrb), .doutb(doutb), .doutb_valid(doutb_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic we, input logic [3:0] be, input logic [3:0] aa,
                      input logic [31:0] d, input logic re, input logic [3:0] ab);
    logic [31:0] v;
    rst = r; wea = we; bea = be; addra = aa; dina = d; reb = re; addrb = ab;
    if (!r && m_ready && re) begin
      v = m_mem[ab];
      if (we && aa == ab)
        for (int i = 0; i < 4; i++) if (be[i]) v[i*8 +: 8] = d[i*8 +: 8];
      due_q.push_back(cyc + RL);
      val_q.push_back(v);
    end
    if (!r && m_ready && we)
      for (int i = 0; i < 4; i++) if (be[i]) m_mem[aa][i*8 +: 8] = d[i*8 +: 8];
    @(posedge clk);
    cyc++;
    if (r) begin
      m_ready = 1'b0; m_clr = DEPTH;
      due_q.delete(); val_q.delete();
      exp_dout = '0; exp_valid = 1'b0;
    end else begin
      if (!m_ready) begin
        m_clr--;
        if (m_clr == 0) begin
          m_ready = 1'b1;
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end
      end
      exp_valid = (due_q.size() > 0) && (due_q[0] == cyc);
      if (exp_valid) begin
        exp_dout = val_q.pop_front();
        void'(due_q.pop_front());
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic test_reset();
    int n, nv;
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_checks++; if (doutb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", doutb_valid); end
    n_checks++; if (doutb !== 32'h0) begin n_fail++; $display("FAIL reset_doutb: got %h want 0", doutb); end
    n = 0;
    while (ready !== 1'b1 && n < 40) begin idle(); n++; end
    n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL first_clear_len: got %0d edges want %0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 4'hF, i[3:0], 32'hFFFF_FFFF, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      n_checks++; if (doutb_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %b want 0", doutb_valid); end
      idle(); n++;
    end
    n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL clear_len: got %0d edges want %0d", n, DEPTH); end
    nv = 0;
    for (int j = 0; j < DEPTH + RL; j++) begin
      if (j < DEPTH) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, j[3:0]); else idle();
      if (doutb_valid === 1'b1) begin
        nv++;
        n_checks++; if (doutb !== 32'h0) begin n_fail++; $display("FAIL cleared_word: got %h want 00000000", doutb); end
      end
    end
    n_checks++; if (nv != DEPTH) begin n_fail++; $display("FAIL cleared_reads: got %0d want %0d", nv, DEPTH); end
  endtask

  task automatic test_mid_clear();
    int n, nv;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 4'hF, i[3:0], 32'hA5A5_0000 + 32'(i), 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) idle();
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin idle(); n++; end
    n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL midclear_len: got %0d edges want %0d", n, DEPTH); end
    nv = 0;
    for (int j = 0; j < DEPTH + RL; j++) begin
      if (j < DEPTH) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, j[3:0]); else idle();
      if (doutb_valid === 1'b1) begin
        nv++;
        n_checks++; if (doutb !== 32'h0) begin n_fail++; $display("FAIL midclear_word: got %h want 00000000", doutb); end
      end
    end
    n_checks++; if (nv != DEPTH) begin n_fail++; $display("FAIL midclear_reads: got %0d want %0d", nv, DEPTH); end
  endtask

  task automatic test_byte_lanes();
    int n;
    step(1'b0, 1'b1, 4'hF, 4'd3, 32'h1122_3344, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'b0101, 4'd3, 32'hAABB_CCDD, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
    n = 1;
    while (doutb_valid !== 1'b1 && n < 6) begin idle(); n++; end
    n_checks++; if (n != RL) begin n_fail++; $display("FAIL lanes_latency: got %0d want %0d", n, RL); end
    n_checks++; if (doutb !== 32'h11BB_33DD) begin n_fail++; $display("FAIL lanes_data: got %h want 11bb33dd", doutb); end
    idle();
    n_checks++; if (doutb !== 32'h11BB_33DD || doutb_valid !== 1'b0) begin
      n_fail++; $display("FAIL lanes_hold: got %h/%b want 11bb33dd/0", doutb, doutb_valid); end
  endtask

  task automatic test_collision();
    int n;
    step(1'b0, 1'b1, 4'hF, 4'd7, 32'h0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'hF, 4'd7, 32'hCAFE_F00D, 1'b1, 4'd7);
    n = 1;
    while (doutb_valid !== 1'b1 && n < 6) begin idle(); n++; end
    n_checks++; if (n != RL) begin n_fail++; $display("FAIL coll_latency: got %0d want %0d", n, RL); end
    n_checks++; if (doutb !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL coll_full: got %h want cafef00d", doutb); end
    step(1'b0, 1'b1, 4'hF, 4'd7, 32'h0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'b0011, 4'd7, 32'hCAFE_F00D, 1'b1, 4'd7);
    n = 1;
    while (doutb_valid !== 1'b1 && n < 6) begin idle(); n++; end
    n_checks++; if (doutb !== 32'h0000_F00D) begin n_fail++; $display("FAIL coll_partial: got %h want 0000f00d", doutb); end
    // next-cycle read sees the array copy; different-address traffic is independent
    step(1'b0, 1'b1, 4'hF, 4'd9, 32'h1234_5678, 1'b1, 4'd7);
    n = 1;
    while (doutb_valid !== 1'b1 && n < 6) begin idle(); n++; end
    n_checks++; if (doutb !== 32'h0000_F00D) begin n_fail++; $display("FAIL coll_indep: got %h want 0000f00d", doutb); end
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd9);
    n = 1;
    while (doutb_valid !== 1'b1 && n < 6) begin idle(); n++; end
    n_checks++; if (doutb !== 32'h1234_5678) begin n_fail++; $display("FAIL next_cycle_read: got %h want 12345678", doutb); end
  endtask

  task automatic test_back_to_back();
    int first, k;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 4'hF, i[3:0], 32'(i), 1'b0, 4'h0);
    first = -1; k = 0;
    for (int j = 0; j < DEPTH + RL; j++) begin
      if (j < DEPTH) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, j[3:0]); else idle();
      if (doutb_valid === 1'b1) begin
        if (first < 0) first = j;
        n_checks++; if (doutb !== 32'(k)) begin n_fail++; $display("FAIL b2b_data: got %h want %h", doutb, 32'(k)); end
        k++;
      end
    end
    // j counts from the cycle the first read is presented, so RL edges later is index RL-1
    n_checks++; if (first != RL - 1) begin n_fail++; $display("FAIL b2b_first: got %0d want %0d", first, RL - 1); end
    n_checks++; if (k != DEPTH) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", k, DEPTH); end
  endtask

  task automatic test_ignored_ops();
    int n;
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 4'hF, 4'd2, 32'h5A5A_5A5A, 1'b1, 4'd2);
      n_checks++; if (doutb_valid !== 1'b0) begin n_fail++; $display("FAIL ignored_valid: got %b want 0", doutb_valid); end
    end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ignored_ready: got %b want 1", ready); end
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2);
    n = 1;
    while (doutb_valid !== 1'b1 && n < 6) begin idle(); n++; end
    n_checks++; if (doutb !== 32'h0 || doutb_valid !== 1'b1) begin
      n_fail++; $display("FAIL ignored_data: got %h/%b want 00000000/1", doutb, doutb_valid); end
  endtask

  task automatic test_flush();
    int n;
    step(1'b0, 1'b1, 4'hF, 4'd5, 32'h1234_5678, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5);
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    n_checks++; if (doutb !== 32'h0 || doutb_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_out: got %h/%b want 00000000/0", doutb, doutb_valid); end
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      idle(); n++;
      n_checks++; if (doutb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b want 0", doutb_valid); end
    end
  endtask

  task automatic test_random();
    logic r, we, re;
    logic [3:0] be, aa, ab;
    logic [31:0] d;
    for (int i = 0; i < 500; i++) begin
      r  = ($urandom_range(0, 79) == 0);
      we = $urandom_range(0, 1);
      re = $urandom_range(0, 2) != 0;
      be = 4'($urandom);
      aa = 4'($urandom_range(0, 5));
      ab = 4'($urandom_range(0, 5));
      d  = $urandom;
      step(r, we, be, aa, d, re, ab);
      n_checks++; if (ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready: cyc %0d got %b want %b", cyc, ready, m_ready); end
      n_checks++; if (doutb_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid: cyc %0d got %b want %b", cyc, doutb_valid, exp_valid); end
      n_checks++; if (doutb !== exp_dout) begin n_fail++; $display("FAIL rnd_doutb: cyc %0d got %h want %h", cyc, doutb, exp_dout); end
    end
  endtask

  initial begin
    test_reset();
    test_mid_clear();
    test_byte_lanes();
    test_collision();
    test_back_to_back();
    test_ignored_ops();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
